// File: rtl/cart_bus_ctrl.sv
// rtl/cart_bus_ctrl.sv - cartridge bus sequencer: timed setup/strobe/hold cycles and cartridge reset hold.
// Every pin is a register loaded from the next-state decode, so pins change only on clock edges or reset.
module cart_bus_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 4,
  parameter int HOLD_CYC   = 1,
  parameter int RST_CYC    = 8,
  parameter logic [ADDR_W-1:0] SRAM_LO = 'hA000,
  parameter logic [ADDR_W-1:0] SRAM_HI = 'hBFFF
) (
  input  logic              clock,
  input  logic              reset_l,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rst_req,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] cart_address,
  output logic [DATA_W-1:0] cart_data_out,
  output logic              cart_data_oe,
  input  logic [DATA_W-1:0] cart_data_in,
  output logic              cart_r_enable_l,
  output logic              cart_w_enable_l,
  output logic              cart_cs_sram_l,
  output logic              cart_reset_l
);

  localparam int MAX_A   = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int MAX_B   = (HOLD_CYC > RST_CYC) ? HOLD_CYC : RST_CYC;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  // Counters load N-1 on entry and the state exits when the count reaches zero.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);

  typedef enum logic [2:0] {RST_HOLD, IDLE, SETUP, ACCESS, HOLD} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic                sram_q, sram_d;
  logic                accept, done, in_win;
  logic                ack_q, busy_q, oe_q, r_en_l_q, w_en_l_q, cs_l_q, crst_l_q;
  logic [DATA_W-1:0]   rdata_q, dout_q;
  logic [ADDR_W-1:0]   addr_q;

  assign in_win = (addr >= SRAM_LO) && (addr <= SRAM_HI);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      RST_HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      IDLE: begin
        if (rst_req) begin
          state_d = RST_HOLD;
          cnt_d   = RST_LD;
        end else if (req) begin
          accept = 1'b1;
          if (SETUP_CYC > 0) begin
            state_d = SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = ACCESS;
            cnt_d   = ACCESS_LD;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
          cnt_d   = ACCESS_LD;
        end else cnt_d = cnt_q - 1'b1;
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (HOLD_CYC > 0) begin
            state_d = HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = IDLE;
            done    = 1'b1;
          end
        end else cnt_d = cnt_q - 1'b1;
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done    = 1'b1;
        end else cnt_d = cnt_q - 1'b1;
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = RST_LD;
      end
    endcase
    // On the accepting edge the pins must already reflect the incoming request.
    we_d   = accept ? we : we_q;
    sram_d = accept ? in_win : sram_q;
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= RST_HOLD;
      cnt_q    <= RST_LD;
      we_q     <= 1'b0;
      sram_q   <= 1'b0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b1;
      oe_q     <= 1'b0;
      r_en_l_q <= 1'b1;
      w_en_l_q <= 1'b1;
      cs_l_q   <= 1'b1;
      crst_l_q <= 1'b0;
      rdata_q  <= '0;
      dout_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      sram_q   <= sram_d;
      ack_q    <= done;
      busy_q   <= (state_d != IDLE);
      crst_l_q <= (state_d != RST_HOLD);
      oe_q     <= we_d && (state_d inside {SETUP, ACCESS, HOLD});
      r_en_l_q <= !(!we_d && (state_d inside {SETUP, ACCESS}));
      w_en_l_q <= !(we_d && (state_d == ACCESS));
      cs_l_q   <= !(sram_d && (state_d inside {SETUP, ACCESS, HOLD}));
      if (accept) begin
        addr_q <= addr;
        if (we) dout_q <= wdata;
      end
      if (state_q == ACCESS && cnt_q == '0 && !we_q) rdata_q <= cart_data_in;
    end
  end

  assign ack             = ack_q;
  assign rdata           = rdata_q;
  assign busy            = busy_q;
  assign cart_address    = addr_q;
  assign cart_data_out   = dout_q;
  assign cart_data_oe    = oe_q;
  assign cart_r_enable_l = r_en_l_q;
  assign cart_w_enable_l = w_en_l_q;
  assign cart_cs_sram_l  = cs_l_q;
  assign cart_reset_l    = crst_l_q;

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// tb/tb_cart_bus_ctrl.sv - scoreboard bench for cart_bus_ctrl with a memory-backed cartridge model.
module tb_cart_bus_ctrl;
  localparam int S = 1, A = 4, H = 1, R = 8;

  logic        clock = 1'b0, reset_l = 1'b0, req = 1'b0, we = 1'b0, rst_req = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  wdata = '0;
  logic        ack, busy, cart_data_oe, cart_r_enable_l, cart_w_enable_l, cart_cs_sram_l, cart_reset_l;
  logic [7:0]  rdata, cart_data_out, cart_data_in;
  logic [15:0] cart_address;
  logic [7:0]  mem [0:65535];

  assign cart_data_in = mem[cart_address];
  always #5 clock = ~clock;

  cart_bus_ctrl dut (
    .clock(clock), .reset_l(reset_l), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rst_req(rst_req), .ack(ack), .rdata(rdata), .busy(busy), .cart_address(cart_address),
    .cart_data_out(cart_data_out), .cart_data_oe(cart_data_oe), .cart_data_in(cart_data_in),
    .cart_r_enable_l(cart_r_enable_l), .cart_w_enable_l(cart_w_enable_l),
    .cart_cs_sram_l(cart_cs_sram_l), .cart_reset_l(cart_reset_l)
  );

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  rd;
    logic        sram;
  } exp_t;

  exp_t       q[$];
  int         total = 0, bad = 0;
  logic [7:0] last_rd = '0;
  int         lat = 0, r_lo = 0, w_lo = 0, cs_lo = 0, oe_n = 0, a_bad = 0, d_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor and acceptance model share one negedge process so the queue has one owner.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset_l) begin
        q.delete();
        last_rd = '0;
        lat = 0; r_lo = 0; w_lo = 0; cs_lo = 0; oe_n = 0; a_bad = 0; d_bad = 0;
      end else begin
        if (cart_reset_l) begin
          if (busy) lat++;
          if (!cart_r_enable_l) r_lo++;
          if (!cart_w_enable_l) w_lo++;
          if (!cart_cs_sram_l) cs_lo++;
          if (cart_data_oe) oe_n++;
          if (busy && q.size() > 0) begin
            if (cart_address !== q[0].a) a_bad++;
            if (q[0].wr && cart_data_oe && cart_data_out !== q[0].d) d_bad++;
          end
        end
        if (ack) begin
          if (q.size() == 0) check("spurious_ack", 1, 0);
          else begin
            e = q.pop_front();
            check("latency", lat + 1, S + A + H + 1);
            check("r_low_cycles", r_lo, e.wr ? 0 : S + A);
            check("w_low_cycles", w_lo, e.wr ? A : 0);
            check("cs_low_cycles", cs_lo, e.sram ? S + A + H : 0);
            check("oe_cycles", oe_n, e.wr ? S + A + H : 0);
            check("addr_errors", a_bad, 0);
            check("wdata_errors", d_bad, 0);
            check("rdata", rdata, e.rd);
          end
          lat = 0; r_lo = 0; w_lo = 0; cs_lo = 0; oe_n = 0; a_bad = 0; d_bad = 0;
        end
        if (!busy && req && !rst_req) begin
          e.wr   = we;
          e.a    = addr;
          e.d    = wdata;
          e.sram = (addr >= 16'hA000) && (addr <= 16'hBFFF);
          if (!we) last_rd = mem[addr];
          e.rd   = last_rd;
          q.push_back(e);
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [15:0] a, input logic [7:0] d, output int waited);
    waited = 0;
    req = 1'b1; we = w; addr = a; wdata = d;
    do begin
      @(negedge clock);
      waited++;
    end while (busy && waited < 100);
    if (busy) check("accept_timeout", 1, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    req = 1'b0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("queue_drained", q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1 just after the edge that starts a cartridge-reset hold.
  task automatic count_reset_low(input string name);
    int n = 0;
    @(negedge clock);
    while (!cart_reset_l && n < 100) begin
      n++;
      @(negedge clock);
    end
    check(name, n, R);
    check({name, "_busy_fall"}, busy, 0);
    @(posedge clock);
    #1;
  endtask

  task automatic random_access(input logic allow_b2b);
    int          w;
    logic [15:0] a;
    a = ($urandom_range(0, 2) == 0) ? 16'hA000 + 16'($urandom_range(0, 16'h1FFF)) : 16'($urandom);
    drive(1'($urandom_range(0, 1)), a, 8'($urandom), w);
    if (!(allow_b2b && $urandom_range(0, 2) == 0)) begin
      req = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        rst_req = 1'b1;
        @(posedge clock);
        #1;
        rst_req = 1'b0;
      end
    end
  endtask

  initial begin
    int w;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0147] = 8'h1B;

    @(negedge clock);
    check("rst_cart_reset_l", cart_reset_l, 0);
    check("rst_r_enable_l", cart_r_enable_l, 1);
    check("rst_w_enable_l", cart_w_enable_l, 1);
    check("rst_cs_sram_l", cart_cs_sram_l, 1);
    check("rst_oe", cart_data_oe, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 1);
    check("rst_rdata", rdata, 0);
    check("rst_address", cart_address, 0);
    check("rst_data_out", cart_data_out, 0);
    @(posedge clock);
    #1;
    reset_l = 1'b1;
    count_reset_low("poweron_reset_low");

    drive(1'b0, 16'h0147, 8'h00, w);
    wait_drain();
    check("read_0147_rdata", rdata, 8'h1B);
    drive(1'b1, 16'hA010, 8'h5A, w);
    wait_drain();
    check("rdata_after_write", rdata, 8'h1B);

    drive(1'b0, 16'h9FFF, 8'h00, w);
    drive(1'b0, 16'hC000, 8'h00, w);
    drive(1'b0, 16'hBFFF, 8'h00, w);
    drive(1'b1, 16'hA000, 8'hE7, w);
    wait_drain();

    drive(1'b0, 16'h1234, 8'h00, w);
    drive(1'b1, 16'hB000, 8'hC3, w);
    check("b2b_accept_wait", w, S + A + H + 1);
    wait_drain();

    req = 1'b1; rst_req = 1'b1; we = 1'b0; addr = 16'h2222;
    @(posedge clock);
    #1;
    req = 1'b0; rst_req = 1'b0;
    count_reset_low("rst_req_reset_low");
    check("rst_req_no_access", q.size(), 0);

    for (int i = 0; i < 40; i++) random_access(1'b1);
    wait_drain();

    drive(1'b0, 16'hA123, 8'h00, w);
    req = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_l = 1'b0;
    #1;
    check("abort_r_enable_l", cart_r_enable_l, 1);
    check("abort_cs_sram_l", cart_cs_sram_l, 1);
    check("abort_ack", ack, 0);
    check("abort_cart_reset_l", cart_reset_l, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_l = 1'b1;
    count_reset_low("abort_reset_low");

    for (int i = 0; i < 12; i++) random_access(1'b1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/cart_bus_ctrl.md
CART_BUS_CTRL -- requirements
Module: cart_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 16: cartridge address width.
REQ-002 SHALL have parameter DATA_W, default 8: cartridge data width.
REQ-003 SHALL have parameter SETUP_CYC, default 1: address-setup cycles before the strobe; 0 skips SETUP.
REQ-004 SHALL have parameter ACCESS_CYC, default 4: strobe-active cycles; legal range is at least 1.
REQ-005 SHALL have parameter HOLD_CYC, default 1: address-hold cycles after the strobe; 0 skips HOLD.
REQ-006 SHALL have parameter RST_CYC, default 8: cycles cart_reset_l stays low after a reset; legal range is at least 1.
REQ-007 SHALL have parameters SRAM_LO, default 'hA000, and SRAM_HI, default 'hBFFF: inclusive SRAM chip-select window.
REQ-008 SHALL have ports, in order:
  - clock  in  1  sole clock, rising edge.
  - reset_l  in  1  asynchronous, active-low reset.
  - req  in  1  access request.
  - we  in  1  1 = write, 0 = read.
  - addr  in  ADDR_W  access address.
  - wdata  in  DATA_W  write data.
  - rst_req  in  1  soft cartridge-reset request.
  - ack  out  1  one-cycle completion pulse.
  - rdata  out  DATA_W  captured read data.
  - busy  out  1  high when the block cannot accept req.
  - cart_address  out  ADDR_W  cartridge address pins.
  - cart_data_out  out  DATA_W  data driven to the cartridge.
  - cart_data_oe  out  1  data-pin output enable.
  - cart_data_in  in  DATA_W  data pins from the cartridge.
  - cart_r_enable_l  out  1  read strobe, active-low.
  - cart_w_enable_l  out  1  write strobe, active-low.
  - cart_cs_sram_l  out  1  SRAM select, active-low.
  - cart_reset_l  out  1  cartridge reset, active-low.

Function
REQ-009 SHALL implement FSM states RST_HOLD, IDLE, SETUP, ACCESS, HOLD, with all outputs registered.
REQ-010 In IDLE with rst_req=1, SHALL go to RST_HOLD; rst_req outside IDLE is ignored; when rst_req and req are both high, rst_req wins and req is dropped.
REQ-011 In IDLE with req=1 and rst_req=0, SHALL latch addr/we/wdata and go to SETUP, or to ACCESS if SETUP_CYC=0; req is ignored in every other state, with no queueing.
REQ-012 busy SHALL be 0 only in IDLE.
REQ-013 cart_address SHALL take the latched addr on the accepting edge and hold it through HOLD; in IDLE it holds its last value.
REQ-014 cart_cs_sram_l SHALL be 0 from SETUP through HOLD when SRAM_LO <= addr <= SRAM_HI, and 1 otherwise.
REQ-015 For a read, cart_r_enable_l SHALL be 0 during SETUP and ACCESS; cart_w_enable_l SHALL remain 1.
REQ-016 For a write, cart_w_enable_l SHALL be 0 only during ACCESS; cart_data_oe SHALL be 1 and cart_data_out SHALL equal wdata from SETUP through HOLD.
REQ-017 For a read, cart_data_oe SHALL be 0 throughout.
REQ-018 Each timed state SHALL last exactly its parameter count, using a down-counter of width clog2(max+1).
REQ-019 Read data SHALL be sampled from cart_data_in into rdata on the edge that ends the last ACCESS cycle; rdata holds until the next read completes and is unchanged by writes.
REQ-020 On leaving HOLD (or ACCESS if HOLD_CYC=0), SHALL return to IDLE and assert ack=1 for exactly that first IDLE cycle.
REQ-021 A req sampled in the ack cycle SHALL be accepted, allowing back-to-back accesses.
REQ-022 Latency SHALL be: accept edge to ack high = SETUP_CYC+ACCESS_CYC+HOLD_CYC+1 cycles (7 with defaults).
REQ-023 In RST_HOLD, cart_reset_l SHALL be 0, strobes SHALL be 1, cart_data_oe SHALL be 0, and busy SHALL be 1; after RST_CYC cycles the block goes to IDLE with cart_reset_l=1.

Reset
REQ-024 reset_l=0 SHALL immediately force state RST_HOLD, cart_reset_l=0, cart_r_enable_l=1, cart_w_enable_l=1, cart_cs_sram_l=1, cart_data_oe=0, ack=0, busy=1, and rdata/cart_address/cart_data_out=0.
REQ-025 Reset asserted mid-access SHALL abort the access with no ack; after reset_l rises, RST_HOLD runs its full RST_CYC count.
REQ-026 Counters SHALL reload on reset, with no residual count carried over.

Verification
REQ-027 Power-on: release reset_l -> cart_reset_l low for 8 cycles, then high; busy falls in the same cycle.
REQ-028 Read at 0x0147 with cart_data_in=0x1B during ACCESS -> r_enable low for 5 cycles, cs_sram_l stays 1, ack after 7 cycles, rdata=0x1B.
REQ-029 Write 0x5A to 0xA010 -> cs_sram_l low for 6 cycles, w_enable low for 4 cycles, oe=1 with data 0x5A, ack after 7 cycles; rdata unchanged.
REQ-030 req held high continuously with two addresses -> second access accepted in the first ack cycle; 14 cycles total, with no idle gap between accesses.
REQ-031 reset_l pulsed low during ACCESS -> strobes high within the same cycle, no ack, 8-cycle RST_HOLD after release.
REQ-032 rst_req and req together in IDLE -> RST_HOLD entered, no access performed; boundaries 0x9FFF/0xC000 give cs=1, 0xBFFF gives cs=0.
